// File: rtl/vga_arb_pkg.sv
// Shared types and constants for the VGA frame-buffer memory arbiter.
package vga_arb_pkg;

    localparam int unsigned ADDR_W_DEF = 11;
    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned STAT_W_DEF = 16;
    localparam int unsigned READ_LAT   = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RD1  = 2'd2,
        ST_RD2  = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWN_DISP = 1'b0,
        OWN_HOST = 1'b1
    } owner_e;

    typedef struct packed {
        logic   valid;
        owner_e owner;
    } tag_t;

endpackage

// File: rtl/vga_arb_tag_pipe.sv
// Two-stage valid/owner delay line that follows each memory read and
// produces the read-data capture enables aligned with mem_rdata.
module vga_arb_tag_pipe
    import vga_arb_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   i_valid,
    input  owner_e i_owner,
    output logic   o_cap_disp_c,
    output logic   o_cap_host_c
);

    tag_t r_s1;
    tag_t r_s2;

    // Stage 1 aligns with mem_addr, stage 2 aligns with mem_rdata
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= '{valid: i_valid, owner: i_owner};
            r_s2 <= r_s1;
        end
    end

    assign o_cap_disp_c = r_s2.valid && (r_s2.owner == OWN_DISP);
    assign o_cap_host_c = r_s2.valid && (r_s2.owner == OWN_HOST);

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port image memory arbiter: display reads always win with a fixed
// 3-cycle latency; the host is served on idle (blanking) cycles.
// Optional macro VGA_ARB_STATS_EN adds the host_stall_cnt statistics port.
module vga_fb_arbiter
    import vga_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
`ifdef VGA_ARB_STATS_EN
    ,
    parameter int unsigned STAT_W = STAT_W_DEF
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_rvalid,
    output logic [DATA_W-1:0] disp_rdata,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ack,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef VGA_ARB_STATS_EN
    ,
    output logic [STAT_W-1:0] host_stall_cnt
`endif
);

    arb_state_e        r_state;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_mem_we;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_host_ack;
    logic              r_disp_rvalid;
    logic [DATA_W-1:0] r_disp_rdata;
    logic              r_host_rvalid;
    logic [DATA_W-1:0] r_host_rdata;

    logic   w_decide;
    logic   w_host_go;
    logic   w_rd_issue;
    owner_e w_rd_owner;
    logic   w_cap_disp;
    logic   w_cap_host;

    // Host may only be granted in a decision state and when the display is idle
    assign w_decide   = (r_state == ST_IDLE) || (r_state == ST_WAIT);
    assign w_host_go  = w_decide && !disp_req && host_req;
    assign w_rd_issue = disp_req || (w_host_go && !host_we);
    assign w_rd_owner = disp_req ? OWN_DISP : OWN_HOST;

    // Arbitration FSM with registered memory command and host_ack
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_mem_addr  <= '0;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= '0;
            r_host_ack  <= 1'b0;
        end else begin
            r_mem_we   <= 1'b0;
            r_host_ack <= 1'b0;
            case (r_state)
                ST_IDLE, ST_WAIT: begin
                    if (disp_req) begin
                        r_mem_addr <= disp_addr;
                        r_state    <= host_req ? ST_WAIT : ST_IDLE;
                    end else if (host_req) begin
                        r_mem_addr  <= host_addr;
                        r_mem_we    <= host_we;
                        r_mem_wdata <= host_wdata;
                        r_host_ack  <= 1'b1;
                        r_state     <= host_we ? ST_IDLE : ST_RD1;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_RD1: begin
                    if (disp_req) r_mem_addr <= disp_addr;
                    r_state <= ST_RD2;
                end
                ST_RD2: begin
                    if (disp_req) r_mem_addr <= disp_addr;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    vga_arb_tag_pipe u_tag_pipe (
        .clk          (clk),
        .rst          (rst),
        .i_valid      (w_rd_issue),
        .i_owner      (w_rd_owner),
        .o_cap_disp_c (w_cap_disp),
        .o_cap_host_c (w_cap_host)
    );

    // Capture returning read data into the owner's output register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_disp_rvalid <= 1'b0;
            r_disp_rdata  <= '0;
            r_host_rvalid <= 1'b0;
            r_host_rdata  <= '0;
        end else begin
            r_disp_rvalid <= w_cap_disp;
            r_host_rvalid <= w_cap_host;
            if (w_cap_disp) r_disp_rdata <= mem_rdata;
            if (w_cap_host) r_host_rdata <= mem_rdata;
        end
    end

    assign mem_addr    = r_mem_addr;
    assign mem_we      = r_mem_we;
    assign mem_wdata   = r_mem_wdata;
    assign host_ack    = r_host_ack;
    assign disp_rvalid = r_disp_rvalid;
    assign disp_rdata  = r_disp_rdata;
    assign host_rvalid = r_host_rvalid;
    assign host_rdata  = r_host_rdata;

`ifdef VGA_ARB_STATS_EN
    logic [STAT_W-1:0] r_stall_cnt;
    logic              w_stall;

    assign w_stall = w_decide && host_req && disp_req;

    // Saturating count of cycles the host lost arbitration to the display
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != {STAT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + STAT_W'(1);
        end
    end

    assign host_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Scoreboard bench for vga_fb_arbiter with a behavioural 1-cycle memory.
module tb_vga_fb_arbiter;
    import vga_arb_pkg::*;

    localparam int unsigned AW = 11;
    localparam int unsigned DW = 8;

    typedef struct packed {
        logic [DW-1:0] data;
        int            cyc;
    } rd_exp_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_exp_t;

    logic          clk;
    logic          rst;
    logic          disp_req;
    logic [AW-1:0] disp_addr;
    logic          disp_rvalid;
    logic [DW-1:0] disp_rdata;
    logic          host_req;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic          host_ack;
    logic          host_rvalid;
    logic [DW-1:0] host_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
`ifdef VGA_ARB_STATS_EN
    logic [15:0]   host_stall_cnt;
`endif

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic          mem_init;
    int            cyc;
    int            checks;
    int            failures;

    rd_exp_t disp_q[$];
    rd_exp_t host_q[$];
    wr_exp_t wr_q[$];
    rd_exp_t md_e;
    rd_exp_t mh_e;
    wr_exp_t mw_e;

    vga_fb_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .disp_req    (disp_req),
        .disp_addr   (disp_addr),
        .disp_rvalid (disp_rvalid),
        .disp_rdata  (disp_rdata),
        .host_req    (host_req),
        .host_we     (host_we),
        .host_addr   (host_addr),
        .host_wdata  (host_wdata),
        .host_ack    (host_ack),
        .host_rvalid (host_rvalid),
        .host_rdata  (host_rdata),
        .mem_addr    (mem_addr),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
`ifdef VGA_ARB_STATS_EN
        ,
        .host_stall_cnt (host_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] pix(input logic [AW-1:0] a);
        return a[7:0] ^ 8'h5A;
    endfunction

    // Behavioural single-port memory with one cycle read latency
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < (1 << AW); i++) mem[i] <= pix(AW'(i));
        end else if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
        mem_rdata <= mem[mem_addr];
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pop and compare whenever the DUT presents an output event
    always @(negedge clk) begin
        if (disp_rvalid) begin
            if (disp_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL disp_unexpected rvalid actual=1 expected=0 (cycle %0d)", cyc);
            end else begin
                md_e = disp_q.pop_front();
                chk("disp_rdata", int'(disp_rdata), int'(md_e.data));
                chk("disp_latency_cycle", cyc, md_e.cyc);
            end
        end
        if (host_rvalid) begin
            if (host_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL host_unexpected rvalid actual=1 expected=0 (cycle %0d)", cyc);
            end else begin
                mh_e = host_q.pop_front();
                chk("host_rdata", int'(host_rdata), int'(mh_e.data));
                chk("host_rvalid_cycle", cyc, mh_e.cyc);
            end
        end
        if (mem_we) begin
            if (wr_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL mem_we_unexpected actual=1 expected=0 (cycle %0d)", cyc);
            end else begin
                mw_e = wr_q.pop_front();
                chk("mem_we_addr", int'(mem_addr), int'(mw_e.addr));
                chk("mem_we_wdata", int'(mem_wdata), int'(mw_e.data));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic disp_burst(input logic [AW-1:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            disp_req  = 1'b1;
            disp_addr = base + AW'(i);
            disp_q.push_back('{data: pix(base + AW'(i)), cyc: cyc + int'(READ_LAT)});
            tick();
        end
        disp_req = 1'b0;
    endtask

    task automatic wait_ack(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (host_ack) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++; failures++;
            $display("FAIL host_ack_timeout actual=none expected=ack within 200 cycles");
        end
    endtask

    task automatic host_access(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                               input int exp_ack, input logic [DW-1:0] exp_rd);
        bit ok;
        host_req   = 1'b1;
        host_we    = we;
        host_addr  = a;
        host_wdata = wd;
        if (we) wr_q.push_back('{addr: a, data: wd});
        wait_ack(ok);
        host_req = 1'b0;
        host_we  = 1'b0;
        if (ok) begin
            chk("host_ack_cycle", cyc, exp_ack);
            if (!we) host_q.push_back('{data: exp_rd, cyc: cyc + int'(READ_LAT) - 1});
        end
    endtask

    task automatic host_write_burst(input logic [AW-1:0] base, input int n);
        bit ok;
        int c0;
        c0       = cyc;
        host_req = 1'b1;
        host_we  = 1'b1;
        for (int i = 0; i < n; i++) begin
            host_addr  = base + AW'(i);
            host_wdata = DW'((i + 1) * 17);
            wr_q.push_back('{addr: host_addr, data: host_wdata});
            wait_ack(ok);
            if (ok) chk("wr_burst_ack_cycle", cyc, c0 + 1 + i);
        end
        host_req = 1'b0;
        host_we  = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_disp_rvalid"}, int'(disp_rvalid), 0);
        chk({tag, "_host_rvalid"}, int'(host_rvalid), 0);
        chk({tag, "_host_ack"},    int'(host_ack), 0);
        chk({tag, "_mem_we"},      int'(mem_we), 0);
        chk({tag, "_mem_addr"},    int'(mem_addr), 0);
        chk({tag, "_mem_wdata"},   int'(mem_wdata), 0);
        chk({tag, "_disp_rdata"},  int'(disp_rdata), 0);
        chk({tag, "_host_rdata"},  int'(host_rdata), 0);
`ifdef VGA_ARB_STATS_EN
        chk({tag, "_stall_cnt"},   int'(host_stall_cnt), 0);
`endif
    endtask

    initial begin
        int c0;
        checks     = 0;
        failures   = 0;
        cyc        = 0;
        rst        = 1'b1;
        mem_init   = 1'b1;
        disp_req   = 1'b0;
        disp_addr  = '0;
        host_req   = 1'b0;
        host_we    = 1'b0;
        host_addr  = '0;
        host_wdata = '0;
        repeat (3) tick();
        rst      = 1'b0;
        mem_init = 1'b0;
        check_reset_outputs("reset");

        // Display only: 8 consecutive reads, no memory writes expected
        disp_burst(11'h010, 8);
        repeat (4) tick();

        // Host write then read during blanking
        host_access(1'b1, 11'h123, 8'hA5, cyc + 1, 8'h00);
        repeat (2) tick();
        host_access(1'b0, 11'h123, 8'h00, cyc + 1, 8'hA5);
        repeat (4) tick();
        chk("host_rdata_held", int'(host_rdata), 8'hA5);

        // Back-to-back host writes, then read the middle one back
        host_write_burst(11'h300, 3);
        repeat (2) tick();
        host_access(1'b0, 11'h301, 8'h00, cyc + 1, 8'h22);
        repeat (4) tick();

        // Conflict: host read held through a 20-cycle display burst
        c0 = cyc;
        fork
            disp_burst(11'h200, 20);
            host_access(1'b0, 11'h123, 8'h00, c0 + 21, 8'hA5);
        join
        repeat (4) tick();
`ifdef VGA_ARB_STATS_EN
        chk("host_stall_cnt", int'(host_stall_cnt), 20);
`endif

        // Interleave: display reads issued while the host read is in RD1/RD2
        host_access(1'b0, 11'h302, 8'h00, cyc + 1, 8'h33);
        disp_burst(11'h050, 2);
        repeat (5) tick();

        // Reset while a host read sits in RD1: that read must vanish
        host_access(1'b0, 11'h123, 8'h00, cyc + 1, 8'hA5);
        host_q.delete();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        check_reset_outputs("midreset");
        repeat (4) tick();
        host_access(1'b0, 11'h123, 8'h00, cyc + 1, 8'hA5);
        repeat (6) tick();

        chk("disp_q_drained", disp_q.size(), 0);
        chk("host_q_drained", host_q.size(), 0);
        chk("wr_q_drained",   wr_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
